// File: rtl/cdb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared definitions for the common data bus (CDB) arbiter and its
// consumers (ROB, reservation stations).
//
// Contents:
//   `ROB_TAG_LEN  - width of a reorder-buffer tag (overridable from the build)
//   `XLEN         - datapath width (overridable from the build)
//   cdb_data_t    - one CDB broadcast: valid flag, ROB tag, result value
//   CDB_MAX_FU    - upper bound on the number of requesters the arbiter handles
// ---------------------------------------------------------------------------

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

`ifndef XLEN
`define XLEN 32
`endif

package cdb_arbiter_pkg;

    localparam int CDB_MAX_FU = 8;

    typedef struct packed {
        logic                    valid;
        logic [`ROB_TAG_LEN-1:0] rob_tag;
        logic [`XLEN-1:0]        value;
    } cdb_data_t;

endpackage : cdb_arbiter_pkg

// File: rtl/cdb_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational rotating priority picker. Starting at start_i, the request
// vector is scanned upward with wrap-around from N-1 to 0; the first set bit
// wins.
//
// Ports:
//   req_i    [N-1:0]     request vector
//   start_i  [IDXW-1:0]  index with highest priority this cycle
//   grant_o  [N-1:0]     one-hot (or zero) grant
//   idx_o    [IDXW-1:0]  index of the granted bit (0 when nothing is granted)
//   valid_o              high when some request was granted
// ---------------------------------------------------------------------------

module rr_picker #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [IDXW-1:0] start_i,
    output logic [N-1:0]    grant_o,
    output logic [IDXW-1:0] idx_o,
    output logic            valid_o
);

    // Walk the N positions in priority order. The position is computed as
    // an integer and wrapped by subtraction so that non-power-of-two N
    // never visits an index outside the request vector.
    always_comb begin : pick_logic
        int          pos;
        logic [IDXW-1:0] pos_idx;
        logic        found;

        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;

        for (int k = 0; k < N; k++) begin
            pos = int'(start_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IDXW'(pos);
            if (!found && req_i[pos_idx]) begin
                found            = 1'b1;
                grant_o[pos_idx] = 1'b1;
                idx_o            = pos_idx;
                valid_o          = 1'b1;
            end
        end
    end

endmodule : rr_picker

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Arbitrates NUM_FU functional units for the single common data bus. The
// grant is combinational in the request cycle; the winning FU's tag and value
// are captured into the output register at the grant edge, so each broadcast
// appears exactly one cycle after its grant. One broadcast per cycle is
// sustainable. Nothing is buffered beyond the output register: the grant
// edge is the FU's handshake completion.
//
// Configuration macro:
//   CDB_LOAD_PRIORITY_EN - FU 0 (load unit) wins whenever it requests, unless
//                          another requester has waited STARVE_LIMIT cycles,
//                          in which case plain round-robin decides that cycle.
//                          Without it, arbitration is pure round-robin and no
//                          wait counters are built.
//
// Parameters:
//   NUM_FU        number of requesting FUs (2..8)
//   STARVE_LIMIT  denied cycles before a requester counts as starved
//
// Ports:
//   clock       sole clock, rising edge
//   reset       asynchronous active-low reset
//   fu_req      per-FU request, held with stable tag/value until granted
//   fu_rob_tag  per-FU ROB tag of the completed result
//   fu_value    per-FU result value
//   flush       pipeline squash: no grant, no broadcast, pointer back to 0
//   fu_grant    one-hot-or-zero grant for the current cycle
//   cdb_data    registered broadcast {valid, rob_tag, value}
// ---------------------------------------------------------------------------

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU       = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_FU-1:0]                     fu_req,
    input  logic [NUM_FU-1:0][`ROB_TAG_LEN-1:0]   fu_rob_tag,
    input  logic [NUM_FU-1:0][`XLEN-1:0]          fu_value,
    input  logic                                  flush,
    output logic [NUM_FU-1:0]                     fu_grant,
    output cdb_data_t                             cdb_data
);

    localparam int IDXW = $clog2(NUM_FU);

    if (NUM_FU < 2 || NUM_FU > CDB_MAX_FU || STARVE_LIMIT < 1) begin : g_bad_params
        $error("cdb_arbiter: NUM_FU must be 2..8 and STARVE_LIMIT at least 1");
    end

    logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
    cdb_data_t         cdb_q, cdb_d;

    logic              arb_en;
    logic [NUM_FU-1:0] pick_req;
    logic [NUM_FU-1:0] pick_grant;
    logic [IDXW-1:0]   pick_idx;
    logic              pick_valid;

    logic [NUM_FU-1:0] grant_c;
    logic [IDXW-1:0]   grant_idx;
    logic              grant_valid;

    // Reset is folded into the enable so the grant drops the instant reset
    // is asserted, not just at the next edge.
    assign arb_en   = reset && !flush;
    assign pick_req = arb_en ? fu_req : '0;

    rr_picker #(
        .N    (NUM_FU),
        .IDXW (IDXW)
    ) u_rr_picker (
        .req_i   (pick_req),
        .start_i (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

`ifdef CDB_LOAD_PRIORITY_EN

    localparam int WAITW = $clog2(STARVE_LIMIT + 1);

    logic [NUM_FU-1:0][WAITW-1:0] wait_q, wait_d;
    logic                         starved;

    // Only FUs other than the load unit can override its priority; a
    // counter only reaches the limit while its owner keeps requesting.
    always_comb begin : starve_detect
        starved = 1'b0;
        for (int i = 1; i < NUM_FU; i++) begin
            if (fu_req[i] && (wait_q[i] == WAITW'(STARVE_LIMIT))) begin
                starved = 1'b1;
            end
        end
    end

    // Load-unit priority overrides the rotating pick unless someone starved.
    always_comb begin : grant_select
        grant_c     = pick_grant;
        grant_idx   = pick_idx;
        grant_valid = pick_valid;
        if (arb_en && fu_req[0] && !starved) begin
            grant_c     = NUM_FU'(1);
            grant_idx   = '0;
            grant_valid = 1'b1;
        end
    end

    // Count consecutive denied request cycles, saturating at the limit.
    always_comb begin : wait_next
        wait_d = wait_q;
        for (int i = 0; i < NUM_FU; i++) begin
            if (flush || !fu_req[i] || grant_c[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != WAITW'(STARVE_LIMIT)) begin
                wait_d[i] = wait_q[i] + WAITW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin : wait_reg
        if (!reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

`else

    assign grant_c     = pick_grant;
    assign grant_idx   = pick_idx;
    assign grant_valid = pick_valid;

`endif

    assign fu_grant = grant_c;
    assign cdb_data = cdb_q;

    // Pointer moves just past the winner, including priority grants; a
    // flush restarts the rotation from FU 0.
    always_comb begin : rr_next
        rr_ptr_d = rr_ptr_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else if (grant_valid) begin
            if (grant_idx == IDXW'(NUM_FU - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + IDXW'(1);
            end
        end
    end

    // Tag and value are kept on idle cycles so consumers can still see the
    // last broadcast; only valid is cleared.
    always_comb begin : cdb_next
        cdb_d       = cdb_q;
        cdb_d.valid = 1'b0;
        if (grant_valid) begin
            cdb_d.valid   = 1'b1;
            cdb_d.rob_tag = fu_rob_tag[grant_idx];
            cdb_d.value   = fu_value[grant_idx];
        end
    end

    always_ff @(posedge clock or negedge reset) begin : state_reg
        if (!reset) begin
            rr_ptr_q <= '0;
            cdb_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_q    <= cdb_d;
        end
    end

endmodule : cdb_arbiter

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4: number of functional-unit requesters sharing the CDB (legal range 2..8).
REQ-002 Parameter STARVE_LIMIT, default 8: consecutive denied cycles before a requester is treated as starved (used only under CDB_LOAD_PRIORITY_EN).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 fu_req  input  NUM_FU  per-FU request; held high with stable tag/value until granted.
REQ-006 fu_rob_tag  input  NUM_FU x `ROB_TAG_LEN  ROB tag of each FU's completed result.
REQ-007 fu_value  input  NUM_FU x `XLEN  result value of each FU.
REQ-008 flush  input  1  pipeline squash; discard all in-flight broadcasts.
REQ-009 fu_grant  output  NUM_FU  one-hot-or-zero combinational grant for the current cycle.
REQ-010 cdb_data  output  CDB_DATA  registered broadcast to ROB and reservation stations: valid, rob_tag, value.

Function
REQ-011 At most one fu_grant bit SHALL be high in any cycle; fu_grant[i] high only if fu_req[i] high, reset is high and flush is low.
REQ-012 Arbitration SHALL be round-robin: search starts at rr_ptr and proceeds upward, wrapping from NUM_FU-1 to 0; first requester found wins.
REQ-013 On a grant to index i, rr_ptr SHALL become (i+1) mod NUM_FU at the next edge; with no grant, rr_ptr SHALL hold.
REQ-014 Grant-to-broadcast latency SHALL be exactly one cycle: the edge ending a grant to i loads cdb_data.valid=1, rob_tag=fu_rob_tag[i], value=fu_value[i].
REQ-015 In a cycle with no grant, the next cdb_data.valid SHALL be 0; rob_tag/value hold their previous contents.
REQ-016 A granted FU SHALL treat the grant edge as handshake completion; the arbiter SHALL NOT buffer any request beyond the output register.
REQ-017 Back-to-back grants SHALL be allowed every cycle; full throughput is one broadcast per cycle.
REQ-018 With flush high: fu_grant SHALL be all zero, next cdb_data.valid SHALL be 0, rr_ptr SHALL return to 0.
REQ-019 Flush and requests in the same cycle: flush wins; requesters remain pending and are arbitrated on the next non-flush cycle.
REQ-020 Simultaneous requests from all FUs starting from rr_ptr=0 SHALL be granted in order 0,1,...,NUM_FU-1, then wrap to 0.

Reset
REQ-021 reset low SHALL immediately and asynchronously clear cdb_data (valid=0, rob_tag=0, value=0), rr_ptr=0 and all wait counters.
REQ-022 fu_grant SHALL be all zero while reset is low, including reset asserted mid-operation; a broadcast in progress is lost.
REQ-023 First grant after reset deassertion SHALL follow rr_ptr=0 priority.

Configuration
REQ-024 Macro CDB_LOAD_PRIORITY_EN: when defined, FU 0 (load unit) SHALL win whenever it requests, unless some other requester's wait counter has reached STARVE_LIMIT, in which case round-robin per REQ-012 decides that cycle.
REQ-025 Under CDB_LOAD_PRIORITY_EN, each FU SHALL have a wait counter (width $clog2(STARVE_LIMIT+1)) incrementing per cycle requested-but-not-granted, saturating at STARVE_LIMIT, cleared on grant, flush or request low.
REQ-026 Under CDB_LOAD_PRIORITY_EN, rr_ptr SHALL still update per REQ-013 on every grant, including FU 0 priority grants.
REQ-027 Without the macro, arbitration SHALL be pure round-robin and no wait counters SHALL exist.

Structure
REQ-028 CDB_DATA struct (valid, rob_tag, value) and `ROB_TAG_LEN/`XLEN SHALL come from the shared package/header used by the ROB; no local redefinition.
REQ-029 One sub-module SHALL be used: rr_picker (combinational masked priority picker, inputs req vector and start pointer, output one-hot grant and index).

Verification
REQ-030 Reset low mid-broadcast with fu_req=4'b1111 -> cdb_data.valid=0 same cycle, fu_grant=0; after release first grant=4'b0001.
REQ-031 fu_req=4'b1111 held (each FU re-requesting) for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3; cdb_data.rob_tag follows one cycle later.
REQ-032 rr_ptr=3, fu_req=4'b1001 -> grant FU3, next cycle grant FU0 (wrap), cdb_data.valid high on both following cycles.
REQ-033 FU2 requests tag=5 value=32'hDEAD_BEEF with flush high -> no grant, valid=0 next cycle; flush low -> grant FU2, next cycle cdb_data={1,5,32'hDEAD_BEEF}.
REQ-034 CDB_LOAD_PRIORITY_EN, STARVE_LIMIT=8, FU0 and FU1 request continuously -> FU0 granted 8 cycles, 9th cycle grant FU1, then FU0 again.
REQ-035 Idle cycle with no requests -> cdb_data.valid=0, rr_ptr unchanged, rob_tag/value retain last broadcast.
